// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU bus and status between alu_arbiter and its neighbours.
// master = requesters plus the ALU; slave = the arbiter.
interface alu_arbiter_if #(
    parameter int XLEN = 32
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_rs1;
    logic [XLEN-1:0] req0_rs2;
    logic [2:0]      req0_funct3;
    logic            req0_funct7;

    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_rs1;
    logic [XLEN-1:0] req1_rs2;
    logic [2:0]      req1_funct3;
    logic            req1_funct7;

    logic            flush;

    logic            rsp0_valid;
    logic [XLEN-1:0] rsp0_result;
    logic            rsp0_z;
    logic            rsp1_valid;
    logic [XLEN-1:0] rsp1_result;
    logic            rsp1_z;

    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2;
    logic [2:0]      alu_funct3;
    logic            alu_funct7;
    logic [XLEN-1:0] alu_rd;
    logic            alu_z;

    logic            busy;

    modport slave (
        input  req0_valid, req0_rs1, req0_rs2, req0_funct3, req0_funct7,
        output req0_ready,
        input  req1_valid, req1_rs1, req1_rs2, req1_funct3, req1_funct7,
        output req1_ready,
        input  flush,
        output rsp0_valid, rsp0_result, rsp0_z,
        output rsp1_valid, rsp1_result, rsp1_z,
        output alu_rs1, alu_rs2, alu_funct3, alu_funct7,
        input  alu_rd, alu_z,
        output busy
    );

    modport master (
        output req0_valid, req0_rs1, req0_rs2, req0_funct3, req0_funct7,
        input  req0_ready,
        output req1_valid, req1_rs1, req1_rs2, req1_funct3, req1_funct7,
        input  req1_ready,
        output flush,
        input  rsp0_valid, rsp0_result, rsp0_z,
        input  rsp1_valid, rsp1_result, rsp1_z,
        input  alu_rs1, alu_rs2, alu_funct3, alu_funct7,
        output alu_rd, alu_z,
        input  busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one clocked ALU between two requesters; a tag pipeline
// tracks which port owns each in-flight op so the result can be routed back.
module alu_arbiter #(
    parameter int XLEN    = 32,
    parameter int ALU_LAT = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int L = 1 + ALU_LAT;

    if (ALU_LAT < 1 || ALU_LAT > 4) begin : g_lat_check
        $error("alu_arbiter: ALU_LAT must be in 1..4");
    end

    typedef enum logic {
        PRIO_0 = 1'b0,
        PRIO_1 = 1'b1
    } prio_e;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [2:0]      funct3;
        logic            funct7;
    } alu_op_t;

    prio_e        prio_q;
    prio_e        prio_d;
    logic         grant0;
    logic         grant1;
    logic         accept;
    alu_op_t      op_sel;
    alu_op_t      issue_q;
    logic [L-1:0] tag_valid_q;
    logic [L-1:0] tag_port_q;

    // The port holding priority only wins when both ask; a lone requester always wins.
    assign grant0 = bus.req0_valid && !bus.flush && (!bus.req1_valid || prio_q == PRIO_0);
    assign grant1 = bus.req1_valid && !bus.flush && (!bus.req0_valid || prio_q == PRIO_1);
    assign accept = grant0 || grant1;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the values from before this edge.
        if (!rst_n) begin
            prio_q <= PRIO_0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        // NOTE: default assigned first so every path drives prio_d and no latch is inferred.
        prio_d = prio_q;
        if (grant0) begin
            prio_d = PRIO_1;
        end else if (grant1) begin
            prio_d = PRIO_0;
        end
    end

    always_comb begin
        op_sel = '{rs1: bus.req0_rs1, rs2: bus.req0_rs2,
                   funct3: bus.req0_funct3, funct7: bus.req0_funct7};
        if (grant1) begin
            op_sel = '{rs1: bus.req1_rs1, rs2: bus.req1_rs2,
                       funct3: bus.req1_funct3, funct7: bus.req1_funct7};
        end
    end

    // The ALU bus holds the last accepted op so the ALU inputs stay stable between accepts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_q <= '0;
        end else if (accept) begin
            issue_q <= op_sel;
        end
    end

    assign bus.alu_rs1    = issue_q.rs1;
    assign bus.alu_rs2    = issue_q.rs2;
    assign bus.alu_funct3 = issue_q.funct3;
    assign bus.alu_funct7 = issue_q.funct7;

    // Flush kills every stage at once, including the one being loaded this edge.
    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            tag_valid_q <= '0;
        end else begin
            tag_valid_q <= {tag_valid_q[L-2:0], accept};
        end
    end

    // NOTE: port tags are payload qualified by tag_valid_q, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_port_q <= {tag_port_q[L-2:0], grant1};
    end

    assign bus.rsp0_valid  = tag_valid_q[L-1] && !tag_port_q[L-1];
    assign bus.rsp1_valid  = tag_valid_q[L-1] &&  tag_port_q[L-1];
    assign bus.rsp0_result = bus.alu_rd;
    assign bus.rsp1_result = bus.alu_rd;
    assign bus.rsp0_z      = bus.alu_z;
    assign bus.rsp1_z      = bus.alu_z;

    assign bus.busy = |tag_valid_q;

    a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
        !(grant0 && grant1));
    a_one_rsp : assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.rsp0_valid && bus.rsp1_valid));
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural clocked ALU of ALU_LAT stages.
// Each task drives one scenario and checks its own hand-computed expectations.
module tb_alu_arbiter;
    parameter int ALU_LAT = 1;
    localparam int XLEN = 32;
    localparam int L    = 1 + ALU_LAT;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_arbiter_if #(.XLEN(XLEN)) bus ();

    alu_arbiter #(.XLEN(XLEN), .ALU_LAT(ALU_LAT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RV32 ALU: result appears ALU_LAT cycles after its inputs are presented.
    function automatic logic [XLEN-1:0] alu_eval(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                 input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return f7 ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            3'd3:    return {{(XLEN-1){1'b0}}, a < b};
            3'd4:    return a ^ b;
            3'd5:    return f7 ? XLEN'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    logic [XLEN-1:0] rd_pipe [ALU_LAT];

    always @(posedge clk) begin
        rd_pipe[0] <= alu_eval(bus.alu_rs1, bus.alu_rs2, bus.alu_funct3, bus.alu_funct7);
        for (int i = 1; i < ALU_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bus.alu_rd = rd_pipe[ALU_LAT-1];
    assign bus.alu_z  = (bus.alu_rd == '0);

    task automatic set_req0(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [2:0] f3, input logic f7);
        bus.req0_valid = v; bus.req0_rs1 = a; bus.req0_rs2 = b;
        bus.req0_funct3 = f3; bus.req0_funct7 = f7;
    endtask

    task automatic set_req1(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [2:0] f3, input logic f7);
        bus.req1_valid = v; bus.req1_rs1 = a; bus.req1_rs2 = b;
        bus.req1_funct3 = f3; bus.req1_funct7 = f7;
    endtask

    task automatic idle();
        set_req0(1'b0, '0, '0, 3'd0, 1'b0);
        set_req1(1'b0, '0, '0, 3'd0, 1'b0);
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        set_req0(1'b1, 32'd5, 32'd6, 3'd0, 1'b0);
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL reset_ready0 got %0b want 1", bus.req0_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got %0b%0b want 00", bus.rsp0_valid, bus.rsp1_valid); end
        checks++; if (bus.alu_rs1 !== 32'd0 || bus.alu_funct3 !== 3'd0) begin
            errors++; $display("FAIL reset_alu got rs1=%0h f3=%0h want 0", bus.alu_rs1, bus.alu_funct3); end
        @(negedge clk); #1;
        checks++; if (bus.alu_rs1 !== 32'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset_no_accept got rs1=%0h busy=%0b want 0 0", bus.alu_rs1, bus.busy); end
        idle();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        for (int c = 0; c <= L + 1; c++) begin
            @(negedge clk);
            if (c == 0) set_req0(1'b1, 32'd20, 32'd30, 3'd0, 1'b0);
            else idle();
            #1;
            if (c == 0) begin
                checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
                    errors++; $display("FAIL single_ready got %0b%0b want 10", bus.req0_ready, bus.req1_ready); end
            end
            if (c == 1) begin
                checks++; if (bus.alu_rs1 !== 32'd20 || bus.alu_rs2 !== 32'd30 || bus.busy !== 1'b1) begin
                    errors++; $display("FAIL single_issue got rs1=%0d rs2=%0d busy=%0b want 20 30 1",
                                       bus.alu_rs1, bus.alu_rs2, bus.busy); end
            end
            checks++; if (bus.rsp0_valid !== (c == L) || bus.rsp1_valid !== 1'b0) begin
                errors++; $display("FAIL single_rsp c=%0d got %0b%0b want %0b0", c, bus.rsp0_valid, bus.rsp1_valid, c == L); end
            if (c == L) begin
                checks++; if (bus.rsp0_result !== 32'd50 || bus.rsp0_z !== 1'b0) begin
                    errors++; $display("FAIL single_result got %0d z=%0b want 50 z=0", bus.rsp0_result, bus.rsp0_z); end
            end
            if (c == L + 1) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy got %0b want 0", bus.busy); end
            end
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        for (int c = 0; c <= 4 + L; c++) begin
            logic w0, w1;
            int   r;
            @(negedge clk);
            rst_n = 1'b1;
            if (c < 4) begin
                set_req0(1'b1, 32'd8, 32'd3, 3'd0, 1'b1);
                set_req1(1'b1, 32'd8, 32'd3, 3'd4, 1'b0);
            end else idle();
            #1;
            if (c < 4) begin
                checks++; if (bus.req0_ready !== (c % 2 == 0) || bus.req1_ready !== (c % 2 == 1)) begin
                    errors++; $display("FAIL contention_grant c=%0d got %0b%0b want %0b%0b", c,
                                       bus.req0_ready, bus.req1_ready, c % 2 == 0, c % 2 == 1); end
            end
            r  = c - L;
            w0 = (r >= 0 && r < 4 && r % 2 == 0);
            w1 = (r >= 0 && r < 4 && r % 2 == 1);
            checks++; if (bus.rsp0_valid !== w0 || bus.rsp1_valid !== w1) begin
                errors++; $display("FAIL contention_rsp c=%0d got %0b%0b want %0b%0b", c,
                                   bus.rsp0_valid, bus.rsp1_valid, w0, w1); end
            if (w0) begin
                checks++; if (bus.rsp0_result !== 32'd5 || bus.rsp0_z !== 1'b0) begin
                    errors++; $display("FAIL contention_sub got %0d want 5", bus.rsp0_result); end
            end
            if (w1) begin
                checks++; if (bus.rsp1_result !== 32'd11 || bus.rsp1_z !== 1'b0) begin
                    errors++; $display("FAIL contention_xor got %0d want 11", bus.rsp1_result); end
            end
        end
    endtask

    task automatic test_lone_then_contention();
        int          port_exp [6] = '{1, 1, 1, 1, 0, 1};
        int unsigned res_exp  [6] = '{11, 12, 13, 14, 101, 16};
        for (int c = 0; c <= 6 + L; c++) begin
            logic w0, w1;
            int   r;
            @(negedge clk);
            if (c < 4) begin
                set_req0(1'b0, '0, '0, 3'd0, 1'b0);
                set_req1(1'b1, 32'(c + 1), 32'd10, 3'd0, 1'b0);
            end else if (c < 6) begin
                set_req0(1'b1, 32'd100, 32'd1, 3'd0, 1'b0);
                set_req1(1'b1, 32'(c + 1), 32'd10, 3'd0, 1'b0);
            end else idle();
            #1;
            if (c < 6) begin
                checks++; if (bus.req0_ready !== (port_exp[c] == 0) || bus.req1_ready !== (port_exp[c] == 1)) begin
                    errors++; $display("FAIL lone_grant c=%0d got %0b%0b want port %0d", c,
                                       bus.req0_ready, bus.req1_ready, port_exp[c]); end
            end
            r  = c - L;
            w0 = (r >= 0 && r < 6) ? (port_exp[r] == 0) : 1'b0;
            w1 = (r >= 0 && r < 6) ? (port_exp[r] == 1) : 1'b0;
            checks++; if (bus.rsp0_valid !== w0 || bus.rsp1_valid !== w1) begin
                errors++; $display("FAIL lone_rsp c=%0d got %0b%0b want %0b%0b", c,
                                   bus.rsp0_valid, bus.rsp1_valid, w0, w1); end
            if (w0 || w1) begin
                checks++; if ((w0 ? bus.rsp0_result : bus.rsp1_result) !== res_exp[r]) begin
                    errors++; $display("FAIL lone_result c=%0d got %0d want %0d", c,
                                       w0 ? bus.rsp0_result : bus.rsp1_result, res_exp[r]); end
            end
        end
    endtask

    task automatic test_zero_flag();
        for (int c = 0; c <= 2 + L; c++) begin
            int r;
            @(negedge clk);
            if (c == 0) set_req1(1'b1, 32'd20, 32'd20, 3'd0, 1'b1);
            else if (c == 1) set_req1(1'b1, 32'd20, 32'd30, 3'd6, 1'b0);
            else idle();
            #1;
            if (c < 2) begin
                checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL zero_ready c=%0d got %0b want 1", c, bus.req1_ready); end
            end
            r = c - L;
            checks++; if (bus.rsp1_valid !== (r == 0 || r == 1) || bus.rsp0_valid !== 1'b0) begin
                errors++; $display("FAIL zero_rsp c=%0d got %0b%0b want 0%0b", c,
                                   bus.rsp0_valid, bus.rsp1_valid, r == 0 || r == 1); end
            if (r == 0) begin
                checks++; if (bus.rsp1_result !== 32'd0 || bus.rsp1_z !== 1'b1) begin
                    errors++; $display("FAIL zero_sub got %0d z=%0b want 0 z=1", bus.rsp1_result, bus.rsp1_z); end
            end
            if (r == 1) begin
                checks++; if (bus.rsp1_result !== 32'd30 || bus.rsp1_z !== 1'b0) begin
                    errors++; $display("FAIL zero_or got %0d z=%0b want 30 z=0", bus.rsp1_result, bus.rsp1_z); end
            end
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c <= 4 + L; c++) begin
            logic w0;
            @(negedge clk);
            idle();
            case (c)
                0: set_req0(1'b1, 32'd1, 32'd2, 3'd0, 1'b0);
                1: set_req1(1'b1, 32'd40, 32'd2, 3'd0, 1'b0);
                2: begin bus.flush = 1'b1; set_req0(1'b1, 32'd7, 32'd8, 3'd0, 1'b0); end
                3: set_req0(1'b1, 32'd7, 32'd8, 3'd0, 1'b0);
                default: ;
            endcase
            #1;
            if (c == 2) begin
                checks++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                    errors++; $display("FAIL flush_ready got %0b%0b want 00", bus.req0_ready, bus.req1_ready); end
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %0b want 1", bus.busy); end
            end
            if (c == 3) begin
                checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready got %0b want 1", bus.req0_ready); end
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after got %0b want 0", bus.busy); end
                checks++; if (bus.alu_rs1 !== 32'd40) begin errors++; $display("FAIL flush_alu_hold got %0d want 40", bus.alu_rs1); end
            end
            w0 = (c == 2 && L == 2) || (c == 3 + L);
            checks++; if (bus.rsp0_valid !== w0 || bus.rsp1_valid !== 1'b0) begin
                errors++; $display("FAIL flush_rsp c=%0d got %0b%0b want %0b0", c, bus.rsp0_valid, bus.rsp1_valid, w0); end
            if (w0) begin
                checks++; if (bus.rsp0_result !== ((c == 2) ? 32'd3 : 32'd15)) begin
                    errors++; $display("FAIL flush_result c=%0d got %0d want %0d", c, bus.rsp0_result, (c == 2) ? 3 : 15); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int last;
        last = 5 + L;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            idle();
            rst_n = 1'b1;
            if (c == 0) set_req1(1'b1, 32'd5, 32'd5, 3'd0, 1'b0);
            if (c == 1) set_req0(1'b1, 32'd6, 32'd7, 3'd5, 1'b1);
            if (c == 2) rst_n = 1'b0;
            if (c == last) begin
                set_req0(1'b1, 32'd1, 32'd1, 3'd0, 1'b0);
                set_req1(1'b1, 32'd2, 32'd2, 3'd0, 1'b0);
            end
            #1;
            if (c == 2) begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %0b want 1", bus.busy); end
            end
            if (c == 3) begin
                checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", bus.busy); end
                checks++; if (bus.alu_rs1 !== 32'd0 || bus.alu_rs2 !== 32'd0 ||
                              bus.alu_funct3 !== 3'd0 || bus.alu_funct7 !== 1'b0) begin
                    errors++; $display("FAIL rstmid_alu got rs1=%0h rs2=%0h f3=%0h f7=%0b want 0",
                                       bus.alu_rs1, bus.alu_rs2, bus.alu_funct3, bus.alu_funct7); end
            end
            if (c >= 3) begin
                checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
                    errors++; $display("FAIL rstmid_rsp c=%0d got %0b%0b want 00", c, bus.rsp0_valid, bus.rsp1_valid); end
            end
            if (c == last) begin
                checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
                    errors++; $display("FAIL rstmid_prio got %0b%0b want 10", bus.req0_ready, bus.req1_ready); end
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_lone_then_contention();
        test_zero_flag();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single clocked `alu` instance between two requesters, typically the execute stage (port 0) and the branch/compare unit (port 1). It accepts at most one operation per cycle under valid/ready handshakes, using round-robin priority. It registers the accepted operation onto the ALU input bus and tracks in-flight operations in a tag pipeline. It then routes each ALU result and zero flag back to the requester that issued it.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `ALU_LAT`, 1, cycles from ALU inputs stable to `alu_rd`/`alu_z` valid; legal range 1..4

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req0_valid` / `req1_valid`  in  1  operation offered
- `req0_ready` / `req1_ready`  out  1  operation accepted this cycle when valid && ready
- `req0_rs1`, `req0_rs2` / `req1_rs1`, `req1_rs2`  in  XLEN  operands
- `req0_funct3` / `req1_funct3`  in  3  ALU op select
- `req0_funct7` / `req1_funct7`  in  1  ALU op modifier (SUB/SRA)
- `flush`  in  1  discard all in-flight operations
- `rsp0_valid` / `rsp1_valid`  out  1  one-cycle response pulse
- `rsp0_result`, `rsp1_result`  out  XLEN  result, equal to `alu_rd`
- `rsp0_z`, `rsp1_z`  out  1  zero flag, equal to `alu_z`
- `alu_rs1`, `alu_rs2`  out  XLEN  to ALU
- `alu_funct3`  out  3  to ALU
- `alu_funct7`  out  1  to ALU
- `alu_rd`  in  XLEN  from ALU
- `alu_z`  in  1  from ALU
- `busy`  out  1  at least one operation in flight

## Operation
- **Arbitration:** priority pointer `prio` (0 or 1).
  - `req0_ready = req0_valid && !flush && (!req1_valid || prio==0)`.
  - `req1_ready` is symmetric.
  - At most one ready is high per cycle.
  - Ready never asserts without the matching valid.
- **Pointer update:** on an accept from port i, `prio` becomes the other port. With no accept, `prio` holds.
- **Issue register:** on accept, capture rs1, rs2, funct3, funct7 into the `alu_*` outputs. Otherwise hold the last values.
- **Tag pipeline:** depth L = 1 + ALU_LAT. Each stage holds {valid, port}.
  - Stage 0 loads {accept, granted port} every cycle.
  - Stages shift every cycle; there is no stall.
  - Final-stage valid && port==i drives `rspi_valid`.
- **Routing:** `rsp*_result` and `rsp*_z` are driven combinationally from `alu_rd`/`alu_z`. They are meaningful only while the matching valid is high.
- **Flush:** clears all tag valids at the clock edge, including the stage being loaded. No accept occurs in a flush cycle. Responses already asserted in the flush cycle still complete.
- **Busy:** `busy` = OR of all tag-stage valids.
- **Reset:**
  - `prio`=0, all tag valids 0.
  - `alu_rs1`/`alu_rs2`=0, `alu_funct3`=0, `alu_funct7`=0.
  - All `rsp*_valid`=0, `busy`=0.
  - Readies follow the combinational rule, but nothing is accepted while `rst_n`=0.
  - Reset mid-operation drops all in-flight operations; no response ever appears for them.

## Timing
- Handshake in cycle N → `alu_*` shows the op in cycle N+1 → response pulse in cycle N+1+ALU_LAT (N+2 at default).
- Throughput: one accept per cycle; responses return in accept order, one per cycle maximum.
- Ready depends combinationally on both valids, `flush` and `prio`. Requesters must not make valid depend on ready.
- A requester with valid held high under contention is granted within 2 cycles.
- A lone requester is accepted every cycle regardless of `prio`.

## Test plan
Run at ALU_LAT=1 and ALU_LAT=3.
1. **Single request:** req0 ADD, rs1=20, rs2=30, only valid → `req0_ready` high the same cycle; `rsp0_valid` one pulse exactly L cycles later with result 50, z=0; `rsp1_valid` stays low.
2. **Contention:** both valid continuously from reset release; req0 SUB 8−3, req1 XOR 8^3 → grants 0,1,0,1; responses alternate rsp0=5, rsp1=11, one per cycle, in order.
3. **Lone requester, then contention:** req1 alone issues 4 back-to-back ops → all 4 accepted on consecutive cycles. Then both valid → req0 granted first, because `prio`=0 after the last req1 grant.
4. **Zero flag:** req1 SUB 20−20 → `rsp1_valid` with result 0, z=1. Then req1 OR 20|30 → result 30, z=0.
5. **Flush:** accept two ops, then assert `flush` the cycle after the second accept, with req0 valid in that cycle → req0 is not accepted that cycle; no responses for the flushed ops; `busy` falls the next cycle. The req0 op accepted the following cycle responds normally after L cycles.
6. **Reset mid-operation:** `rst_n`=0 for one cycle while 2 ops are in flight → the next cycle shows all `rsp*_valid`=0, `busy`=0, `alu_*`=0. No response pulse appears afterwards, and the next contention grants req0 first.
